// File: rtl/arbitro_ram.sv
// Round-robin arbiter/sequencer placing two word requesters onto a single-port RAM bank.
// Each access takes three cycles (IDLE, ACCESO, RESP) and completes with a one-cycle ack.
module arbitro_ram #(
    parameter int ANCHO_DATOS = 32,
    parameter int ANCHO_DIR   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   we0,
    input  logic                   we1,
    input  logic [ANCHO_DIR-1:0]   dir0,
    input  logic [ANCHO_DIR-1:0]   dir1,
    input  logic [ANCHO_DATOS-1:0] dato0,
    input  logic [ANCHO_DATOS-1:0] dato1,
    output logic                   ack0,
    output logic                   ack1,
    output logic [ANCHO_DATOS-1:0] lect0,
    output logic [ANCHO_DATOS-1:0] lect1,
    output logic                   ocupado,
    output logic                   ram_we,
    output logic [ANCHO_DIR-1:0]   ram_dir,
    output logic [ANCHO_DATOS-1:0] ram_dato,
    input  logic [ANCHO_DATOS-1:0] ram_lect
);

    typedef enum logic [1:0] {IDLE, ACCESO, RESP} estado_t;

    estado_t estado;
    logic    ultimo;
    logic    ganador;
    logic    cmd_we;
    logic    gana1;

    // Under contention the port that was not served last wins.
    always_comb begin
        gana1 = req1 & (~req0 | ~ultimo);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= IDLE;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            ram_we   <= 1'b0;
            ocupado  <= 1'b0;
            ram_dir  <= '0;
            ram_dato <= '0;
            lect0    <= '0;
            lect1    <= '0;
            ultimo   <= 1'b1;
            ganador  <= 1'b0;
            cmd_we   <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (estado)
                IDLE: begin
                    if (req0 || req1) begin
                        ganador  <= gana1;
                        cmd_we   <= gana1 ? we1 : we0;
                        ram_we   <= gana1 ? we1 : we0;
                        ram_dir  <= gana1 ? dir1 : dir0;
                        ram_dato <= gana1 ? dato1 : dato0;
                        ocupado  <= 1'b1;
                        estado   <= ACCESO;
                    end
                end
                ACCESO: begin
                    ram_we <= 1'b0;
                    estado <= RESP;
                end
                RESP: begin
                    if (ganador) begin
                        ack1 <= 1'b1;
                        if (!cmd_we) lect1 <= ram_lect;
                    end else begin
                        ack0 <= 1'b1;
                        if (!cmd_we) lect0 <= ram_lect;
                    end
                    ultimo  <= ganador;
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
                default: begin
                    ram_we  <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_ram.sv
// Directed self-checking bench for arbitro_ram with a behavioural 16x32 RAM bank.
module tb_arbitro_ram;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [3:0]  dir0 = '0, dir1 = '0;
    logic [31:0] dato0 = '0, dato1 = '0;
    logic        ack0, ack1, ocupado, ram_we;
    logic [31:0] lect0, lect1, ram_dato, ram_lect;
    logic [3:0]  ram_dir;

    logic [31:0] mem [16];
    int          nwrites = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    arbitro_ram #(.ANCHO_DATOS(32), .ANCHO_DIR(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .dir0(dir0), .dir1(dir1), .dato0(dato0), .dato1(dato1),
        .ack0(ack0), .ack1(ack1), .lect0(lect0), .lect1(lect1),
        .ocupado(ocupado), .ram_we(ram_we), .ram_dir(ram_dir),
        .ram_dato(ram_dato), .ram_lect(ram_lect)
    );

    // Bank model: contents restored to a known pattern while reset is high.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A50000 + 32'(i);
        end else if (ram_we) begin
            mem[ram_dir] <= ram_dato;
            nwrites = nwrites + 1;
        end
    end
    assign ram_lect = mem[ram_dir];

    task automatic access(input int port, input logic we, input logic [3:0] dir,
                          input logic [31:0] dato, output int lat);
        if (port == 0) begin
            req0 = 1'b1; we0 = we; dir0 = dir; dato0 = dato;
        end else begin
            req1 = 1'b1; we1 = we; dir1 = dir; dato1 = dato;
        end
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if ((port == 0 && ack0) || (port == 1 && ack1)) begin
                lat = c;
                break;
            end
        end
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++;
        if ({ack0, ack1, ram_we, ocupado} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {ack0, ack1, ram_we, ocupado});
        end
        checks++;
        if (ram_dir !== 4'd0 || ram_dato !== 32'd0) begin
            errors++;
            $display("FAIL reset_ram_bus: got dir=%0d dato=%h expected 0/0", ram_dir, ram_dato);
        end
        checks++;
        if (lect0 !== 32'd0 || lect1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_lect: got %h/%h expected 0/0", lect0, lect1);
        end
    endtask

    task automatic test_write_read();
        int lat;
        int w0;
        w0 = nwrites;
        access(0, 1'b1, 4'd3, 32'hDEADBEEF, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL wr_latency: got %0d expected 3", lat);
        end
        checks++;
        if (mem[3] !== 32'hDEADBEEF || nwrites !== w0 + 1) begin
            errors++;
            $display("FAIL wr_ram: got mem3=%h writes=%0d expected DEADBEEF/%0d", mem[3], nwrites - w0, 1);
        end
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL wr_ocupado_ack: got %b expected 0", ocupado);
        end
        access(0, 1'b0, 4'd3, 32'h0, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL rd_latency: got %0d expected 3", lat);
        end
        checks++;
        if (lect0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_data: got %h expected DEADBEEF", lect0);
        end
        checks++;
        if (nwrites !== w0 + 1) begin
            errors++;
            $display("FAIL rd_no_write: got %0d writes expected 1", nwrites - w0);
        end
    endtask

    task automatic test_boundary();
        int lat;
        access(1, 1'b1, 4'd15, 32'h12345678, lat);
        checks++;
        if (lat !== 3 || mem[15] !== 32'h12345678) begin
            errors++;
            $display("FAIL bnd_write: got lat=%0d mem15=%h expected 3/12345678", lat, mem[15]);
        end
        access(1, 1'b0, 4'd15, 32'h0, lat);
        checks++;
        if (lat !== 3 || lect1 !== 32'h12345678) begin
            errors++;
            $display("FAIL bnd_read: got lat=%0d lect1=%h expected 3/12345678", lat, lect1);
        end
        checks++;
        if (mem[14] !== 32'hA5A5000E) begin
            errors++;
            $display("FAIL bnd_neighbour: got %h expected A5A5000E", mem[14]);
        end
        checks++;
        if (lect0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bnd_lect0_held: got %h expected DEADBEEF", lect0);
        end
    endtask

    task automatic test_isolation();
        int lat;
        bit changed;
        access(0, 1'b0, 4'd5, 32'h0, lat);
        checks++;
        if (lat !== 3 || lect0 !== 32'hA5A50005) begin
            errors++;
            $display("FAIL iso_read: got lat=%0d lect0=%h expected 3/A5A50005", lat, lect0);
        end
        req1 = 1'b1; we1 = 1'b1; dir1 = 4'd5; dato1 = 32'h0BADF00D;
        changed = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (lect0 !== 32'hA5A50005) changed = 1'b1;
            if (ack1) begin
                lat = c;
                break;
            end
        end
        req1 = 1'b0;
        checks++;
        if (lat !== 3 || changed) begin
            errors++;
            $display("FAIL iso_write: got lat=%0d lect0_changed=%0d expected 3/0", lat, changed);
        end
        checks++;
        if (mem[5] !== 32'h0BADF00D || lect1 !== 32'h12345678) begin
            errors++;
            $display("FAIL iso_effects: got mem5=%h lect1=%h expected 0BADF00D/12345678", mem[5], lect1);
        end
    endtask

    task automatic test_reset_mid();
        bit acked;
        req0 = 1'b1; we0 = 1'b1; dir0 = 4'd7; dato0 = 32'hCAFEF00D;
        @(posedge clk); #1;
        checks++;
        if (ram_we !== 1'b1 || ocupado !== 1'b1 || ram_dir !== 4'd7) begin
            errors++;
            $display("FAIL mid_acceso: got we=%b ocup=%b dir=%0d expected 1/1/7", ram_we, ocupado, ram_dir);
        end
        reset = 1'b1;
        req0 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ram_we !== 1'b0 || ocupado !== 1'b0 || ack0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got we=%b ocup=%b ack0=%b expected 0/0/0", ram_we, ocupado, ack0);
        end
        reset = 1'b0;
        acked = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ack0 || ack1 || ocupado) acked = 1'b1;
        end
        checks++;
        if (acked) begin
            errors++;
            $display("FAIL mid_no_ack: got ack/ocupado activity after reset expected none");
        end
    endtask

    task automatic test_contention();
        int t0, t1;
        bit both;
        pulse_reset();
        req0 = 1'b1; we0 = 1'b0; dir0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; dir1 = 4'd2;
        t0 = -1; t1 = -1; both = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ack0 && ack1) both = 1'b1;
            if (ack0) begin t0 = c; req0 = 1'b0; end
            if (ack1) begin t1 = c; req1 = 1'b0; end
            if (t0 > 0 && t1 > 0) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (t0 !== 3 || t1 !== 6 || both) begin
            errors++;
            $display("FAIL cont_order: got ack0@%0d ack1@%0d both=%0d expected 3/6/0", t0, t1, both);
        end
        checks++;
        if (lect0 !== 32'hA5A50001 || lect1 !== 32'hA5A50002) begin
            errors++;
            $display("FAIL cont_data: got %h/%h expected A5A50001/A5A50002", lect0, lect1);
        end
    endtask

    task automatic test_sustained();
        int gp[4];
        int gc[4];
        int n;
        int expc[4] = '{3, 6, 9, 12};
        int expp[4] = '{0, 1, 0, 1};
        bit bad;
        req0 = 1'b1; we0 = 1'b0; dir0 = 4'd4;
        req1 = 1'b1; we1 = 1'b0; dir1 = 4'd5;
        n = 0; bad = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (ack0 && ack1) bad = 1'b1;
            if ((ack0 || ack1) && n < 4) begin
                gp[n] = ack1 ? 1 : 0;
                gc[n] = c;
                n++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (n !== 4 || bad) begin
            errors++;
            $display("FAIL sus_count: got %0d grants dual_ack=%0d expected 4/0", n, bad);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (gp[i] !== expp[i] || gc[i] !== expc[i]) begin
                errors++;
                $display("FAIL sus_grant%0d: got port%0d@%0d expected port%0d@%0d", i, gp[i], gc[i], expp[i], expc[i]);
            end
        end
        checks++;
        if (lect0 !== 32'hA5A50004 || lect1 !== 32'hA5A50005) begin
            errors++;
            $display("FAIL sus_data: got %h/%h expected A5A50004/A5A50005", lect0, lect1);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_boundary();
        test_isolation();
        test_reset_mid();
        test_contention();
        test_sustained();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
